// File: rtl/freq_count_latch.sv
// Measurement end of a frequency meter: synchronises the unknown signal, counts its rising
// edges in BCD while the gate is open, and latches the count to the display on request.
module freq_count_latch #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic                  cnt_clean,
  input  logic                  cnt_en,
  input  logic                  lat_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  lat_valid
);

  localparam int unsigned W = 4 * DIGITS;

  // Synchroniser chains; the last stage is the synchronised view of each input.
  logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
  logic [SYNC_STAGES-1:0] clean_sync_q, clean_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d;

  logic sig_s, clean_s, en_s, lat_s;
  logic sig_d_q, sig_d_d;
  logic lat_d_q, lat_d_d;
  logic sig_rise, lat_rise;

  logic [W-1:0] cnt_q, cnt_d, cnt_inc;
  logic         ovf_cnt_q, ovf_cnt_d;
  logic         inc_wrap;

  logic [W-1:0] bcd_out_q, bcd_out_d;
  logic         overflow_q, overflow_d;
  logic         lat_valid_q, lat_valid_d;

  always_comb begin
    sig_sync_d   = {sig_sync_q[SYNC_STAGES-2:0], sig_in};
    clean_sync_d = {clean_sync_q[SYNC_STAGES-2:0], cnt_clean};
    en_sync_d    = {en_sync_q[SYNC_STAGES-2:0], cnt_en};
    lat_sync_d   = {lat_sync_q[SYNC_STAGES-2:0], lat_en};
  end

  assign sig_s   = sig_sync_q[SYNC_STAGES-1];
  assign clean_s = clean_sync_q[SYNC_STAGES-1];
  assign en_s    = en_sync_q[SYNC_STAGES-1];
  assign lat_s   = lat_sync_q[SYNC_STAGES-1];

  always_comb begin
    sig_d_d  = sig_s;
    lat_d_d  = lat_s;
    sig_rise = sig_s & ~sig_d_q;
    lat_rise = lat_s & ~lat_d_q;
  end

  // Ripple-carry BCD increment; a carry out of the top digit means the count wrapped.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    cnt_inc = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    inc_wrap = carry;
  end

  // Clear outranks counting so a clear during an open gate always wins.
  always_comb begin
    cnt_d     = cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (!clean_s) begin
      cnt_d     = '0;
      ovf_cnt_d = 1'b0;
    end else if (en_s && sig_rise) begin
      cnt_d = cnt_inc;
      if (inc_wrap) begin
        ovf_cnt_d = 1'b1;
      end
    end
  end

  // Latch samples the counter register itself, i.e. the value before this cycle's update.
  always_comb begin
    bcd_out_d   = bcd_out_q;
    overflow_d  = overflow_q;
    lat_valid_d = lat_rise;
    if (lat_rise) begin
      bcd_out_d  = cnt_q;
      overflow_d = ovf_cnt_q;
    end
  end

  // Latch history resets high so a lat_en already high at reset release does not latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_sync_q   <= '0;
      clean_sync_q <= '1;
      en_sync_q    <= '0;
      lat_sync_q   <= '1;
      sig_d_q      <= 1'b0;
      lat_d_q      <= 1'b1;
      cnt_q        <= '0;
      ovf_cnt_q    <= 1'b0;
      bcd_out_q    <= '0;
      overflow_q   <= 1'b0;
      lat_valid_q  <= 1'b0;
    end else begin
      sig_sync_q   <= sig_sync_d;
      clean_sync_q <= clean_sync_d;
      en_sync_q    <= en_sync_d;
      lat_sync_q   <= lat_sync_d;
      sig_d_q      <= sig_d_d;
      lat_d_q      <= lat_d_d;
      cnt_q        <= cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      bcd_out_q    <= bcd_out_d;
      overflow_q   <= overflow_d;
      lat_valid_q  <= lat_valid_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign overflow  = overflow_q;
  assign lat_valid = lat_valid_q;

endmodule

// File: tb/tb_freq_count_latch.sv
// Bench for freq_count_latch: an 8-digit and a 2-digit instance share stimulus and are
// checked against an integer-count model.
module tb_freq_count_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sig_in, cnt_clean, cnt_en, lat_en;
  logic [31:0] bcd8;
  logic        ovf8, lv8;
  logic [7:0]  bcd2;
  logic        ovf2, lv2;

  int total = 0;
  int bad   = 0;
  int lv8_n = 0;
  int lv2_n = 0;

  int m8, m2;
  bit o8, o2, en_m, clean_m;

  freq_count_latch #(.DIGITS(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .cnt_clean(cnt_clean), .cnt_en(cnt_en),
    .lat_en(lat_en), .bcd_out(bcd8), .overflow(ovf8), .lat_valid(lv8)
  );

  freq_count_latch #(.DIGITS(2), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .sig_in(sig_in), .cnt_clean(cnt_clean), .cnt_en(cnt_en),
    .lat_en(lat_en), .bcd_out(bcd2), .overflow(ovf2), .lat_valid(lv2)
  );

  // Count latch pulses; on every update also verify each displayed digit is decimal.
  always @(negedge clk) begin
    if (lv8 === 1'b1) begin
      lv8_n++;
      for (int i = 0; i < 8; i++) begin
        total++;
        if (bcd8[4*i +: 4] > 4'd9) begin
          bad++;
          $display("FAIL nibble8[%0d]: got %h want <=9", i, bcd8[4*i +: 4]);
        end
      end
    end
    if (lv2 === 1'b1) lv2_n++;
  end

  function automatic logic [31:0] to_bcd(int n, int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic clk_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_inc();
    m8 = (m8 + 1) % 100000000;
    if (m8 == 0) o8 = 1'b1;
    m2 = (m2 + 1) % 100;
    if (m2 == 0) o2 = 1'b1;
  endtask

  task automatic model_clear();
    m8 = 0; m2 = 0; o8 = 1'b0; o2 = 1'b0;
  endtask

  task automatic set_ctrl(bit en, bit clean);
    cnt_en    = en;
    cnt_clean = clean;
    en_m      = en;
    clean_m   = clean;
    if (!clean) model_clear();
    clk_n(6);
  endtask

  task automatic pulses(int n, bit rnd);
    int hi, lo;
    for (int k = 0; k < n; k++) begin
      hi = rnd ? int'($urandom_range(1, 3)) : 3;
      lo = rnd ? int'($urandom_range(1, 3)) : 3;
      sig_in = 1'b1;
      clk_n(hi);
      sig_in = 1'b0;
      clk_n(lo);
      if (en_m && clean_m) model_inc();
    end
    clk_n(5);
  endtask

  task automatic check_latch(string name);
    logic [31:0] e8, e2w;
    logic [7:0]  e2;
    lat_en = 1'b0;
    clk_n(5);
    lv8_n  = 0;
    lv2_n  = 0;
    lat_en = 1'b1;
    clk_n(8);
    e8  = to_bcd(m8, 8);
    e2w = to_bcd(m2, 2);
    e2  = e2w[7:0];
    total++; if (lv8_n != 1)  begin bad++; $display("FAIL %s lv8 pulses: got %0d want 1", name, lv8_n); end
    total++; if (lv2_n != 1)  begin bad++; $display("FAIL %s lv2 pulses: got %0d want 1", name, lv2_n); end
    total++; if (bcd8 !== e8) begin bad++; $display("FAIL %s bcd8: got %h want %h", name, bcd8, e8); end
    total++; if (ovf8 !== o8) begin bad++; $display("FAIL %s ovf8: got %b want %b", name, ovf8, o8); end
    total++; if (bcd2 !== e2) begin bad++; $display("FAIL %s bcd2: got %h want %h", name, bcd2, e2); end
    total++; if (ovf2 !== o2) begin bad++; $display("FAIL %s ovf2: got %b want %b", name, ovf2, o2); end
  endtask

  task automatic test_reset();
    reset = 1'b1; sig_in = 1'b0; cnt_en = 1'b0; cnt_clean = 1'b1; lat_en = 1'b0;
    clk_n(3);
    total++; if (bcd8 !== 32'h0) begin bad++; $display("FAIL reset bcd8: got %h want 0", bcd8); end
    total++; if (ovf8 !== 1'b0)  begin bad++; $display("FAIL reset ovf8: got %b want 0", ovf8); end
    total++; if (lv8 !== 1'b0)   begin bad++; $display("FAIL reset lv8: got %b want 0", lv8); end
    total++; if (bcd2 !== 8'h0)  begin bad++; $display("FAIL reset bcd2: got %h want 0", bcd2); end
    lv8_n = 0;
    reset = 1'b0;
    model_clear();
    en_m = 1'b0; clean_m = 1'b1;
    clk_n(6);
    total++; if (lv8_n != 0) begin bad++; $display("FAIL reset release lv8: got %0d want 0", lv8_n); end
  endtask

  task automatic test_basic();
    set_ctrl(1'b0, 1'b0);
    clk_n(4);
    set_ctrl(1'b1, 1'b1);
    pulses(1234, 1'b0);
    set_ctrl(1'b0, 1'b1);
    check_latch("basic1234");
  endtask

  task automatic test_gate_clear();
    set_ctrl(1'b1, 1'b0);
    pulses(50, 1'b0);
    set_ctrl(1'b0, 1'b0);
    set_ctrl(1'b0, 1'b1);
    check_latch("clear_gate");
  endtask

  task automatic test_overflow();
    set_ctrl(1'b1, 1'b0);
    set_ctrl(1'b1, 1'b1);
    pulses(105, 1'b1);
    set_ctrl(1'b0, 1'b1);
    check_latch("ovf105");
    set_ctrl(1'b1, 1'b0);
    set_ctrl(1'b1, 1'b1);
    pulses(3, 1'b1);
    set_ctrl(1'b0, 1'b1);
    check_latch("ovf_cleared");
  endtask

  task automatic test_latch_vs_clear();
    logic [31:0] e8;
    set_ctrl(1'b1, 1'b0);
    set_ctrl(1'b1, 1'b1);
    pulses(77, 1'b1);
    set_ctrl(1'b0, 1'b1);
    e8 = to_bcd(m8, 8);
    lat_en = 1'b0;
    clk_n(5);
    lv8_n     = 0;
    lat_en    = 1'b1;
    cnt_clean = 1'b0;
    clean_m   = 1'b0;
    clk_n(8);
    model_clear();
    total++; if (bcd8 !== e8) begin bad++; $display("FAIL latch_vs_clear bcd8: got %h want %h", bcd8, e8); end
    total++; if (bcd2 !== 8'h77) begin bad++; $display("FAIL latch_vs_clear bcd2: got %h want 77", bcd2); end
    clk_n(100);
    total++; if (lv8_n != 1) begin bad++; $display("FAIL latch_held lv8 pulses: got %0d want 1", lv8_n); end
    set_ctrl(1'b0, 1'b1);
    check_latch("after_clear");
  endtask

  task automatic test_reset_mid_gate();
    set_ctrl(1'b1, 1'b0);
    set_ctrl(1'b1, 1'b1);
    pulses(99, 1'b1);
    set_ctrl(1'b0, 1'b1);
    check_latch("pre99");
    set_ctrl(1'b1, 1'b1);
    pulses(40, 1'b1);
    lv8_n = 0;
    lv2_n = 0;
    reset = 1'b1;
    clk_n(3);
    total++; if (bcd8 !== 32'h0) begin bad++; $display("FAIL midreset bcd8: got %h want 0", bcd8); end
    total++; if (ovf2 !== 1'b0)  begin bad++; $display("FAIL midreset ovf2: got %b want 0", ovf2); end
    reset = 1'b0;
    model_clear();
    clk_n(10);
    total++; if (lv8_n != 0) begin bad++; $display("FAIL midreset lv8 pulses: got %0d want 0", lv8_n); end
    total++; if (lv2_n != 0) begin bad++; $display("FAIL midreset lv2 pulses: got %0d want 0", lv2_n); end
    set_ctrl(1'b0, 1'b1);
    check_latch("post_reset");
  endtask

  task automatic test_max_rate();
    set_ctrl(1'b1, 1'b0);
    set_ctrl(1'b1, 1'b1);
    for (int k = 0; k < 200; k++) begin
      sig_in = ~sig_in;
      @(negedge clk);
    end
    for (int k = 0; k < 100; k++) model_inc();
    clk_n(5);
    set_ctrl(1'b0, 1'b1);
    check_latch("max_rate");
  endtask

  task automatic test_random();
    bit en;
    for (int r = 0; r < 6; r++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) set_ctrl(en, 1'b0);
      set_ctrl(en, 1'b1);
      pulses(int'($urandom_range(0, 250)), 1'b1);
      set_ctrl(1'b0, 1'b1);
      check_latch("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gate_clear();
    test_overflow();
    test_latch_vs_clear();
    test_reset_mid_gate();
    test_max_rate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
